// File: rtl/piccolo80_key_schedule.sv
// Piccolo-80 key schedule: captures an 80-bit master key, drives the
// whitening keys and streams one round-key pair per accepted beat.
module piccolo80_key_schedule #(
  parameter int NUM_ROUNDS = 25
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:79] key_in,
  input  logic        key_load,
  output logic        key_ready,
  input  logic        restart,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [0:31] rk_out,
  output logic [0:4]  rk_round,
  output logic        rk_last,
  output logic [0:63] wk_out,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [4:0] LAST_R = 5'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [0:79] key_q, key_d;
  logic [4:0]  r_q, r_d;
  logic [2:0]  m_q, m_d;

  logic [15:0] k0, k1, k2, k3, k4;
  logic [4:0]  c;
  logic [31:0] con;
  logic [31:0] sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      r_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      r_q     <= r_d;
      m_q     <= m_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    r_d     = r_q;
    m_d     = m_q;
    unique case (state_q)
      IDLE, DONE: begin
        // A new key takes precedence over replaying the stored one
        if (key_load) begin
          key_d   = key_in;
          r_d     = '0;
          m_d     = '0;
          state_d = RUN;
        end else if (restart && state_q == DONE) begin
          r_d     = '0;
          m_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rk_ready) begin
          r_d = r_q + 5'd1;
          m_d = (m_q == 3'd4) ? 3'd0 : m_q + 3'd1;
          if (r_q == LAST_R) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign k0 = key_q[0:15];
  assign k1 = key_q[16:31];
  assign k2 = key_q[32:47];
  assign k3 = key_q[48:63];
  assign k4 = key_q[64:79];

  // m mirrors r mod 5 so the selection needs no divider
  always_comb begin
    sel = {k2, k3};
    unique case (1'b1)
      (m_q == 3'd1 || m_q == 3'd4): sel = {k0, k1};
      (m_q == 3'd3):                sel = {k4, k4};
      default:                      ;
    endcase
  end

  assign c   = r_q + 5'd1;
  assign con = {c, 5'b0, c, 2'b0, c, 5'b0, c} ^ 32'h0F1E2D3C;

  assign rk_out    = con ^ sel;
  assign rk_round  = r_q;
  assign rk_valid  = (state_q == RUN);
  assign rk_last   = (state_q == RUN) && (r_q == LAST_R);
  assign done      = (state_q == DONE);
  assign key_ready = (state_q != RUN);

  assign wk_out = {key_q[0:7],   key_q[24:31],
                   key_q[16:23], key_q[8:15],
                   key_q[64:71], key_q[56:63],
                   key_q[48:55], key_q[72:79]};

endmodule
